// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolver: prediction queue, mispredict detection,
// registered BHT/BTB/RAS update bus, redirect pulse and fixed-length flush recovery.
module branch_resolve_unit #(
  parameter int DEPTH          = 8,
  parameter int RECOVER_CYCLES = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pf_valid,
  input  logic [31:0] pf_pc,
  input  logic        pf_pred_taken,
  input  logic [31:0] pf_pred_target,
  output logic        pf_ready,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [1:0]  ex_br_type,
  input  logic [1:0]  ex_jtype,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        upd_valid,
  output logic [7:0]  upd_bht_index,
  output logic [6:0]  upd_btb_index,
  output logic [22:0] upd_btb_tag,
  output logic [1:0]  upd_br_type,
  output logic [1:0]  upd_jtype,
  output logic        upd_taken,
  output logic [31:0] upd_address,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_mispredicts
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW:0]   r_wptr, r_rptr;
  logic [31:0]   r_q_pc    [DEPTH];
  logic [31:0]   r_q_tgt   [DEPTH];
  logic          r_q_taken [DEPTH];
  logic [15:0]   r_stat_br, r_stat_mis;

  logic        w_run, w_empty, w_full, w_push, w_pop, w_mispredict, w_upd;
  logic [31:0] w_next_pc, w_head_pc, w_head_tgt;

  assign w_run      = (r_state == S_RUN);
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign pf_ready   = w_run && !w_full;
  assign w_push     = pf_valid && pf_ready;
  assign w_pop      = ex_valid && w_run;
  assign w_head_pc  = r_q_pc[r_rptr[AW-1:0]];
  assign w_head_tgt = r_q_tgt[r_rptr[AW-1:0]];
  assign w_next_pc  = ex_taken ? ex_target : ex_pc + 32'd4;

  // An underflow pop has no prediction to trust, so it both redirects and trains.
  assign w_mispredict = w_pop && (w_empty || (w_head_pc != ex_pc) || (w_head_tgt != w_next_pc));
  assign w_upd        = w_pop && ((ex_br_type != 2'b00) || (ex_jtype != 2'b00) || w_empty);

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mis;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wptr[AW-1:0]]    <= pf_pc;
      r_q_tgt[r_wptr[AW-1:0]]   <= pf_pred_target;
      r_q_taken[r_wptr[AW-1:0]] <= pf_pred_taken;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_mispredict) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RUN: begin
        if (w_mispredict) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = CW'(RECOVER_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (r_cnt == '0) w_state_nxt = S_RUN;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Update payload and redirect target only load on their strobes and hold otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      upd_valid      <= 1'b0;
      upd_bht_index  <= '0;
      upd_btb_index  <= '0;
      upd_btb_tag    <= '0;
      upd_br_type    <= '0;
      upd_jtype      <= '0;
      upd_taken      <= 1'b0;
      upd_address    <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      r_stat_br      <= '0;
      r_stat_mis     <= '0;
    end else begin
      upd_valid      <= w_upd;
      redirect_valid <= w_mispredict;
      if (w_upd) begin
        upd_bht_index <= ex_pc[9:2];
        upd_btb_index <= ex_pc[8:2];
        upd_btb_tag   <= ex_pc[31:9];
        upd_br_type   <= ex_br_type;
        upd_jtype     <= ex_jtype;
        upd_taken     <= ex_taken;
        upd_address   <= ex_target;
      end
      if (w_mispredict) redirect_pc <= w_next_pc;
      if (w_upd && (r_stat_br != 16'hFFFF))        r_stat_br  <= r_stat_br + 16'd1;
      if (w_mispredict && (r_stat_mis != 16'hFFFF)) r_stat_mis <= r_stat_mis + 16'd1;
    end
  end
endmodule
